// File: rtl/serial_bus_arbiter_if.sv
// Shared serial bus arbitration signals: per-master requests from the masters,
// ownership and occupancy indications from the arbiter.
interface serial_bus_arbiter_if #(
    parameter int NUM_MASTERS = 3,
    parameter int ID_WIDTH    = 2
);
    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] grant;
    logic [ID_WIDTH-1:0]    grant_id;
    logic                   bus_util;
    logic                   timeout_err;

    modport master (
        output req,
        input  grant,
        input  grant_id,
        input  bus_util,
        input  timeout_err
    );

    modport slave (
        input  req,
        output grant,
        output grant_id,
        output bus_util,
        output timeout_err
    );
endinterface

// File: rtl/serial_bus_arbiter.sv
// Round-robin owner arbiter for the single-wire serial bus, with an enforced
// turnaround gap between owners and a hold-time limit that revokes stuck masters.
module serial_bus_arbiter_chk #(
    parameter int NUM_MASTERS = 3
) (
    input logic                   clk,
    input logic                   rst,
    input logic [NUM_MASTERS-1:0] grant,
    input logic                   bus_util,
    input logic                   timeout_err
);
    a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
    a_util_match:   assert property (@(posedge clk) disable iff (rst) bus_util == (|grant));
    a_err_unowned:  assert property (@(posedge clk) disable iff (rst) timeout_err |-> !bus_util);
endmodule

module serial_bus_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int ID_WIDTH    = 2,
    parameter int HOLD_LIMIT  = 255,
    parameter int GAP_CYCLES  = 2
) (
    input logic                 clk,
    input logic                 rst,
    serial_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWNED   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam int CNT_W = (HOLD_LIMIT > 0) ? $clog2(HOLD_LIMIT + 1) : 1;
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam bit LIMIT_EN = (HOLD_LIMIT != 0);

    localparam logic [CNT_W-1:0]       CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(HOLD_LIMIT - 1);
    localparam logic [CNT_W-1:0]       CNT_ONE  = CNT_W'(1'b1);
    localparam logic [GAP_W-1:0]       GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [GAP_W-1:0]       GAP_ONE  = GAP_W'(1'b1);
    localparam logic [ID_WIDTH-1:0]    ID_LAST  = ID_WIDTH'(NUM_MASTERS - 1);
    localparam logic [ID_WIDTH-1:0]    ID_ONE   = ID_WIDTH'(1'b1);
    localparam logic [NUM_MASTERS-1:0] SEL_ONE  = NUM_MASTERS'(1'b1);

    // First set bit of elig scanning upward from start with wrap; MSB flags a hit.
    function automatic logic [ID_WIDTH:0] rr_pick(
        input logic [NUM_MASTERS-1:0] elig,
        input logic [ID_WIDTH-1:0]    start
    );
        logic                found;
        logic [ID_WIDTH-1:0] idx;
        int                  pos;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            pos = (int'(start) + k) % NUM_MASTERS;
            for (int m = 0; m < NUM_MASTERS; m++) begin
                if (!found && (m == pos) && elig[m]) begin
                    found = 1'b1;
                    idx   = ID_WIDTH'(m);
                end
            end
        end
        return {found, idx};
    endfunction

    state_t                 state_r;
    logic [NUM_MASTERS-1:0] grant_r;
    logic [ID_WIDTH-1:0]    grant_id_r;
    logic                   bus_util_r;
    logic                   timeout_err_r;
    logic [ID_WIDTH-1:0]    ptr_r;
    logic [CNT_W-1:0]       hold_cnt_r;
    logic [GAP_W-1:0]       gap_cnt_r;
    logic [NUM_MASTERS-1:0] blocked_r;

    logic [NUM_MASTERS-1:0] elig_s;
    logic                   pick_found_s;
    logic [ID_WIDTH-1:0]    pick_id_s;
    logic [NUM_MASTERS-1:0] grant_pick_s;
    logic                   owner_req_s;
    logic                   limit_hit_s;
    logic [ID_WIDTH-1:0]    ptr_next_s;

    // Arbitration candidates, release decisions and next round-robin start point.
    always_comb begin
        elig_s                    = bus.req & ~blocked_r;
        {pick_found_s, pick_id_s} = rr_pick(elig_s, ptr_r);
        grant_pick_s              = SEL_ONE << pick_id_s;
        // grant_r is one-hot on the owner, so this reads req of the current owner.
        owner_req_s               = |(bus.req & grant_r);
        limit_hit_s               = LIMIT_EN && (hold_cnt_r == CNT_LAST);
        if (grant_id_r == ID_LAST) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = grant_id_r + ID_ONE;
        end
    end

    // Ownership FSM with all bus-facing outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            grant_r       <= '0;
            grant_id_r    <= '0;
            bus_util_r    <= 1'b0;
            timeout_err_r <= 1'b0;
            ptr_r         <= '0;
            hold_cnt_r    <= '0;
            gap_cnt_r     <= '0;
            blocked_r     <= '0;
        end else begin
            timeout_err_r <= 1'b0;
            // A revoked master is forgiven as soon as it drops its request.
            blocked_r     <= blocked_r & bus.req;
            case (state_r)
                ST_IDLE: begin
                    if (pick_found_s) begin
                        grant_r    <= grant_pick_s;
                        grant_id_r <= pick_id_s;
                        bus_util_r <= 1'b1;
                        hold_cnt_r <= '0;
                        state_r    <= ST_OWNED;
                    end
                end
                ST_OWNED: begin
                    if (hold_cnt_r != CNT_MAX) begin
                        hold_cnt_r <= hold_cnt_r + CNT_ONE;
                    end
                    // A voluntary drop wins over a limit hit on the same cycle.
                    if (!owner_req_s || limit_hit_s) begin
                        grant_r    <= '0;
                        bus_util_r <= 1'b0;
                        gap_cnt_r  <= '0;
                        ptr_r      <= ptr_next_s;
                        state_r    <= ST_RELEASE;
                        if (owner_req_s) begin
                            timeout_err_r <= 1'b1;
                            blocked_r     <= (blocked_r & bus.req) | grant_r;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (gap_cnt_r == GAP_LAST) begin
                        state_r <= ST_IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GAP_ONE;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    grant_r    <= '0;
                    bus_util_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant       = grant_r;
    assign bus.grant_id    = grant_id_r;
    assign bus.bus_util    = bus_util_r;
    assign bus.timeout_err = timeout_err_r;

    serial_bus_arbiter_chk #(
        .NUM_MASTERS(NUM_MASTERS)
    ) u_chk (
        .clk        (clk),
        .rst        (rst),
        .grant      (grant_r),
        .bus_util   (bus_util_r),
        .timeout_err(timeout_err_r)
    );
endmodule

// File: doc/serial_bus_arbiter.md
# serial_bus_arbiter

Arbiter and sequencer for the shared single-wire serial data bus. Grants bus ownership to one of several masters at a time using round-robin fairness, and drives `bus_util` so idle slaves track bus occupancy. Enforces a turnaround gap between owners so every slave returns to its idle state. Revokes ownership from a master that holds the bus past a cycle limit. Sits at the top level beside the masters; slaves only observe `bus_util`.

## Interface
- `NUM_MASTERS`, 3: number of requesting masters (2..8).
- `ID_WIDTH`, 2: width of `grant_id`; must be ≥ clog2(`NUM_MASTERS`).
- `HOLD_LIMIT`, 255: maximum ownership cycles before forced revoke; 0 disables the timeout.
- `GAP_CYCLES`, 2: cycles `bus_util` is held low after each release (≥1).
- `clk`  in  1  bus clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  NUM_MASTERS  per-master level request; held high for the whole transaction.
- `grant`  out  NUM_MASTERS  one-hot ownership; all zero when the bus is unowned.
- `grant_id`  out  ID_WIDTH  index of the current/last owner.
- `bus_util`  out  1  high while any master owns the bus.
- `timeout_err`  out  1  one-cycle pulse on forced revoke.

## Operation
- Reset (asynchronous, effective immediately, including mid-ownership):
  - state = IDLE;
  - `grant`, `grant_id`, `bus_util`, `timeout_err` = 0;
  - round-robin pointer `ptr` = 0, hold counter = 0, gap counter = 0, blocked mask = 0.
- States: IDLE, OWNED, RELEASE.
- IDLE:
  - Eligible set = `req` & ~blocked.
  - If non-empty, pick the first eligible index scanning `ptr`, `ptr`+1, …, wrapping from NUM_MASTERS-1 to 0.
  - Registered result: `grant` bit set, `grant_id` = index, `bus_util` = 1, hold counter = 0, state = OWNED.
- OWNED:
  - Hold counter increments each cycle.
  - If `req[grant_id]` = 0: normal release → RELEASE.
  - Else if `HOLD_LIMIT` ≠ 0 and the counter reaches `HOLD_LIMIT`-1: forced revoke → RELEASE, `timeout_err` = 1 for one cycle, blocked[`grant_id`] = 1.
  - Either release updates `ptr` = (`grant_id`+1) mod NUM_MASTERS.
  - Requests from other masters are ignored during OWNED.
- RELEASE:
  - `grant` = 0, `bus_util` = 0; `grant_id` holds its value.
  - Gap counter counts `GAP_CYCLES`, then state = IDLE.
- Blocked mask: blocked[i] clears on any cycle where `req[i]` = 0. A revoked master must deassert `req` for at least one cycle before it can win again.
- Simultaneous events:
  - Owner drops `req` on the same cycle the limit is reached: normal release, no `timeout_err`, not blocked.
  - A blocked master's `req` drop and re-raise on consecutive cycles is legal.
- `grant` is always one-hot or zero; `bus_util` == |`grant` at every cycle.

## Timing
- Grant latency: `req` sampled high in IDLE at edge k → `grant`/`bus_util` high after edge k (one registered cycle).
- Ownership length: `HOLD_LIMIT` cycles max with `grant` high.
- Release latency: `req` low sampled at edge k → `grant`/`bus_util` low after edge k.
- Turnaround: `bus_util` low for exactly `GAP_CYCLES` cycles in RELEASE, plus one IDLE cycle before the next grant. Minimum unowned window is `GAP_CYCLES`+1 cycles.
- `timeout_err` is asserted in the first RELEASE cycle only.
- Hold counter width is clog2(`HOLD_LIMIT`+1); the counter saturates and never wraps.

## Test plan
- Reset: assert `rst` with `req`=3'b111 → `grant`=0, `grant_id`=0, `bus_util`=0, `timeout_err`=0 with no clock edge; release `rst` → master 0 granted one cycle later.
- Single request: `req`=3'b010 from idle → next cycle `grant`=3'b010, `grant_id`=1, `bus_util`=1. Drop `req` after 6 cycles → `grant`=0 next cycle, `bus_util` low 2 cycles, then IDLE.
- Round robin: all three masters re-raise `req` immediately after each release, each holding 5 cycles → grant order 0,1,2,0,1 with 3 idle cycles between owners.
- Timeout: `HOLD_LIMIT`=16, master 2 holds `req` for 40 cycles, master 0 also requesting → master 2 owns exactly 16 cycles, `timeout_err` single pulse, master 0 granted next. Master 2 is not regranted until its `req` has been low ≥1 cycle.
- Boundary: owner drops `req` on the cycle the counter hits `HOLD_LIMIT`-1 → normal release, `timeout_err` stays 0, master not blocked.
- Mid-ownership reset: `rst` pulsed while master 1 owns → `grant`/`bus_util` drop asynchronously. After reset, `ptr`=0, so master 0 wins over master 1 when both request.
